// File: rtl/input_unit.sv
// Mesh router input port: first-word fall-through flit FIFO, XY route request for the
// head flit, back-pressure and head-of-line wait counter. Optional macro: INPUT_UNIT_EARLY_HOLD_EN.
module input_unit #(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 4,
    parameter int X_W            = 2,
    parameter int Y_W            = 2,
    parameter int LOCAL_X        = 0,
    parameter int LOCAL_Y        = 0,
    parameter int DEADLOCK_LIMIT = 128
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [DATA_W-1:0]                    dataIn,
    input  logic                                 writeRequest,
    input  logic                                 readRequest,
    output logic [DATA_W-1:0]                    dataOut,
    output logic [4:0]                           outputPortRequest,
    output logic                                 holdPort,
    output logic [$clog2(DEADLOCK_LIMIT):0]      wait_count,
    output logic                                 overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WC_W  = $clog2(DEADLOCK_LIMIT) + 1;

    typedef enum logic [4:0] {
        PORT_NONE  = 5'b00000,
        PORT_LOCAL = 5'b00001,
        PORT_WEST  = 5'b00010,
        PORT_SOUTH = 5'b00100,
        PORT_EAST  = 5'b01000,
        PORT_NORTH = 5'b10000
    } port_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [WC_W-1:0]   wait_q;
    logic              overflow_q;

    logic              empty, full, pop, push, drop;
    logic [DATA_W-1:0] head;
    logic [X_W-1:0]    dest_x;
    logic [Y_W-1:0]    dest_y;
    port_t             route;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign pop   = readRequest && !empty;
    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign push  = writeRequest && (!full || pop);
    assign drop  = writeRequest && full && !pop;

    // NOTE: storage has no reset; validity is tracked by count, so clearing the array
    // would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= dataIn;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) overflow_q <= 1'b1;
        end
    end

    // Head-of-line wait: restarts on every pop and while empty, saturates at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q <= '0;
        end else if (pop || empty) begin
            wait_q <= '0;
        end else if (!(&wait_q)) begin
            wait_q <= wait_q + 1'b1;
        end
    end

    assign head   = mem[rd_ptr];
    assign dest_x = head[X_W-1:0];
    assign dest_y = head[X_W+Y_W-1:X_W];

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        route = PORT_NONE;
        if (!empty) begin
            if (dest_x > X_W'(LOCAL_X))      route = PORT_EAST;
            else if (dest_x < X_W'(LOCAL_X)) route = PORT_WEST;
            else if (dest_y > Y_W'(LOCAL_Y)) route = PORT_NORTH;
            else if (dest_y < Y_W'(LOCAL_Y)) route = PORT_SOUTH;
            else                             route = PORT_LOCAL;
        end
    end

    assign dataOut           = empty ? '0 : head;
    assign outputPortRequest = route;
    assign wait_count        = wait_q;
    assign overflow          = overflow_q;

`ifdef INPUT_UNIT_EARLY_HOLD_EN
    // Raised one slot early to absorb one cycle of link latency upstream.
    assign holdPort = (count >= CNT_W'(DEPTH - 1));
`else
    assign holdPort = full;
`endif

endmodule

// File: tb/tb_input_unit.sv
// Directed, table-driven bench for input_unit (LOCAL_X=1, LOCAL_Y=1, DEPTH=4).
// Honours INPUT_UNIT_EARLY_HOLD_EN when computing the expected holdPort.
module tb_input_unit;

`ifdef INPUT_UNIT_EARLY_HOLD_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] dataIn = '0;
    logic        writeRequest = 1'b0;
    logic        readRequest = 1'b0;
    logic [31:0] dataOut;
    logic [4:0]  outputPortRequest;
    logic        holdPort;
    logic [7:0]  wait_count;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    input_unit #(
        .DATA_W(32), .DEPTH(4), .X_W(2), .Y_W(2),
        .LOCAL_X(1), .LOCAL_Y(1), .DEADLOCK_LIMIT(128)
    ) dut (
        .clk(clk),
        .reset(reset),
        .dataIn(dataIn),
        .writeRequest(writeRequest),
        .readRequest(readRequest),
        .dataOut(dataOut),
        .outputPortRequest(outputPortRequest),
        .holdPort(holdPort),
        .wait_count(wait_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] din;
        logic [31:0] dout;
        logic [4:0]  req;
        int          cnt;
        logic        ovf;
        int          wc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic exp_hold(input int cnt);
        return EARLY ? (cnt >= 3) : (cnt == 4);
    endfunction

    task automatic add(input logic wr, input logic rd, input logic [31:0] din,
                       input logic [31:0] dout, input logic [4:0] req, input int cnt,
                       input logic ovf, input int wc);
        vec_t v;
        v.wr = wr; v.rd = rd; v.din = din; v.dout = dout;
        v.req = req; v.cnt = cnt; v.ovf = ovf; v.wc = wc;
        vecs.push_back(v);
    endtask

    // Drive inputs on the falling edge, sample 1 ns after the rising edge.
    task automatic cycle(input logic wr, input logic rd, input logic [31:0] din);
        @(negedge clk);
        writeRequest = wr;
        readRequest  = rd;
        dataIn       = din;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " dataOut"}, dataOut, 32'h0);
        check({tag, " req"}, {27'h0, outputPortRequest}, 32'h0);
        check({tag, " hold"}, {31'h0, holdPort}, 32'h0);
        check({tag, " wait"}, {24'h0, wait_count}, 32'h0);
        check({tag, " ovf"}, {31'h0, overflow}, 32'h0);
    endtask

    initial begin
        // XY routing, LOCAL=(1,1); low nibble of each flit is {Y,X}.
        add(1, 0, 32'hF100_0006, 32'hF100_0006, 5'b01000, 1, 0, 0);
        add(1, 0, 32'hF200_0004, 32'hF100_0006, 5'b01000, 2, 0, 1);
        add(1, 0, 32'hF300_0009, 32'hF100_0006, 5'b01000, 3, 0, 2);
        add(1, 0, 32'hF400_0001, 32'hF100_0006, 5'b01000, 4, 0, 3);
        add(1, 1, 32'hF500_0005, 32'hF200_0004, 5'b00010, 4, 0, 0);
        add(0, 1, 32'h0,         32'hF300_0009, 5'b10000, 3, 0, 0);
        add(0, 1, 32'h0,         32'hF400_0001, 5'b00100, 2, 0, 0);
        add(0, 1, 32'h0,         32'hF500_0005, 5'b00001, 1, 0, 0);
        add(0, 1, 32'h0,         32'h0,         5'b00000, 0, 0, 0);
        add(0, 1, 32'h0,         32'h0,         5'b00000, 0, 0, 0);
        // Fill, drop a 5th write, drain: only the first four come back.
        add(1, 0, 32'hA010_0005, 32'hA010_0005, 5'b00001, 1, 0, 0);
        add(1, 0, 32'hA020_0005, 32'hA010_0005, 5'b00001, 2, 0, 1);
        add(1, 0, 32'hA030_0005, 32'hA010_0005, 5'b00001, 3, 0, 2);
        add(1, 0, 32'hA040_0005, 32'hA010_0005, 5'b00001, 4, 0, 3);
        add(1, 0, 32'hA050_0005, 32'hA010_0005, 5'b00001, 4, 1, 4);
        add(0, 1, 32'h0,         32'hA020_0005, 5'b00001, 3, 1, 0);
        add(0, 1, 32'h0,         32'hA030_0005, 5'b00001, 2, 1, 0);
        add(0, 1, 32'h0,         32'hA040_0005, 5'b00001, 1, 1, 0);
        add(0, 1, 32'h0,         32'h0,         5'b00000, 0, 1, 0);
        // Full FIFO with simultaneous write and pop: next pops return flits 2..5.
        add(1, 0, 32'hB010_000A, 32'hB010_000A, 5'b01000, 1, 1, 0);
        add(1, 0, 32'hB020_000A, 32'hB010_000A, 5'b01000, 2, 1, 1);
        add(1, 0, 32'hB030_000A, 32'hB010_000A, 5'b01000, 3, 1, 2);
        add(1, 0, 32'hB040_000A, 32'hB010_000A, 5'b01000, 4, 1, 3);
        add(1, 1, 32'hB050_000A, 32'hB020_000A, 5'b01000, 4, 1, 0);
        add(0, 1, 32'h0,         32'hB030_000A, 5'b01000, 3, 1, 0);
        add(0, 1, 32'h0,         32'hB040_000A, 5'b01000, 2, 1, 0);
        add(0, 1, 32'h0,         32'hB050_000A, 5'b01000, 1, 1, 0);
        add(0, 1, 32'h0,         32'h0,         5'b00000, 0, 1, 0);

        // Reset state and idle behaviour.
        #12;
        check_idle_outputs("reset");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 32'h0);
            check($sformatf("idle%0d wait", i), {24'h0, wait_count}, 32'h0);
            check($sformatf("idle%0d req", i), {27'h0, outputPortRequest}, 32'h0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].wr, vecs[i].rd, vecs[i].din);
            check($sformatf("v%0d dataOut", i), dataOut, vecs[i].dout);
            check($sformatf("v%0d req", i), {27'h0, outputPortRequest}, {27'h0, vecs[i].req});
            check($sformatf("v%0d hold", i), {31'h0, holdPort}, {31'h0, exp_hold(vecs[i].cnt)});
            check($sformatf("v%0d ovf", i), {31'h0, overflow}, {31'h0, vecs[i].ovf});
            check($sformatf("v%0d wait", i), {24'h0, wait_count}, 32'(vecs[i].wc));
        end

        // Clear sticky overflow, then wait_count saturation on a stalled head flit.
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst2 ovf", {31'h0, overflow}, 32'h0);
        reset = 1'b1;
        cycle(1, 0, 32'hC000_0005);
        check("sat start", {24'h0, wait_count}, 32'h0);
        repeat (100) cycle(0, 0, 32'h0);
        check("sat 100", {24'h0, wait_count}, 32'd100);
        repeat (200) cycle(0, 0, 32'h0);
        check("sat 300", {24'h0, wait_count}, 32'd255);
        cycle(0, 0, 32'h0);
        check("sat hold", {24'h0, wait_count}, 32'd255);
        check("sat dataOut", dataOut, 32'hC000_0005);
        cycle(0, 1, 32'h0);
        check("sat pop wait", {24'h0, wait_count}, 32'h0);
        check("sat pop empty", dataOut, 32'h0);

        // Hold threshold, last-slot acceptance, drop, then asynchronous reset mid-stream.
        cycle(1, 0, 32'hD010_0006);
        cycle(1, 0, 32'hD020_0006);
        cycle(1, 0, 32'hD030_0006);
        check("hold at 3", {31'h0, holdPort}, {31'h0, EARLY});
        cycle(1, 0, 32'hD040_0006);
        check("hold at 4", {31'h0, holdPort}, 32'h1);
        check("ovf at 4", {31'h0, overflow}, 32'h0);
        cycle(1, 0, 32'hD050_0006);
        check("drop ovf", {31'h0, overflow}, 32'h1);
        check("drop head", dataOut, 32'hD010_0006);
        check("drop req", {27'h0, outputPortRequest}, 32'h8);
        cycle(0, 0, 32'h0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_idle_outputs("async");
        @(negedge clk);
        reset = 1'b1;
        cycle(0, 0, 32'h0);
        check("post rst dataOut", dataOut, 32'h0);
        check("post rst hold", {31'h0, holdPort}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
